// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed hex display driver; new values are applied only at frame boundaries
module seven_seg_scanner #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 25000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic                    i_Load,
  input  logic [4*NUM_DIGITS-1:0] i_Value,
  input  logic                    i_Blank_Lead,
  input  logic                    i_Enable,
  output logic [6:0]              o_Segments,
  output logic [NUM_DIGITS-1:0]   o_Digit_En,
  output logic                    o_Pending,
  output logic                    o_Frame_Done
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };
  logic [PW-1:0]           p_q, p_d;
  logic [DW-1:0]           d_q, d_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d, disp_q, disp_d;
  logic                    pend_q, pend_d, fd_q, fd_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d, zero_up, onehot;
  logic                    wrap, boundary, blank, dark, z;
  logic [3:0]              nib;
  always_comb begin
    wrap     = p_q == PW'(SCAN_DIV - 1);
    boundary = wrap && d_q == DW'(NUM_DIGITS - 1);
    p_d      = wrap ? '0 : p_q + 1'b1;
    d_d      = !wrap ? d_q : boundary ? '0 : d_q + 1'b1;
    shadow_d = i_Load ? i_Value : shadow_q;
    disp_d   = i_Load && boundary ? i_Value : boundary && pend_q ? shadow_q : disp_q;
    pend_d   = boundary ? 1'b0 : i_Load | pend_q;
    // zero_up[k] is set when nibbles k..top of the display are all zero
    zero_up  = '0;
    z        = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      z          = z && disp_q[4*k +: 4] == 4'd0;
      zero_up[k] = z;
    end
    nib      = disp_q[4*d_q +: 4];
    blank    = i_Blank_Lead && d_q != '0 && zero_up[d_q];
    dark     = !i_Enable || p_q == '0;
    onehot   = NUM_DIGITS'(1) << d_q;
    seg_d    = dark || blank ? SEG_OFF : SEG_LUT[nib] ^ SEG_OFF;
    dig_d    = dark ? DIG_OFF : onehot ^ DIG_OFF;
    fd_d     = boundary;
  end
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      p_q      <= '0;
      d_q      <= '0;
      shadow_q <= '0;
      disp_q   <= '0;
      pend_q   <= 1'b0;
      seg_q    <= SEG_OFF;
      dig_q    <= DIG_OFF;
      fd_q     <= 1'b0;
    end else begin
      p_q      <= p_d;
      d_q      <= d_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      seg_q    <= seg_d;
      dig_q    <= dig_d;
      fd_q     <= fd_d;
    end
  end
  assign o_Segments   = seg_q;
  assign o_Digit_En   = dig_q;
  assign o_Pending    = pend_q;
  assign o_Frame_Done = fd_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed scan/load/blank/enable/reset vectors checked through an expectation queue
module tb_seven_seg_scanner;
  logic        clk = 1'b0, rst_n = 1'b0, load = 1'b0, blank = 1'b0, en = 1'b1;
  logic [15:0] value = '0;
  logic [6:0]  seg;
  logic [3:0]  dig;
  logic        pend, fd;

  always #5 clk = ~clk;

  seven_seg_scanner #(.NUM_DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Load(load), .i_Value(value),
    .i_Blank_Lead(blank), .i_Enable(en),
    .o_Segments(seg), .o_Digit_En(dig), .o_Pending(pend), .o_Frame_Done(fd)
  );

  typedef struct {
    int         tag;
    logic [6:0] seg;
    logic [3:0] dig;
    logic       fd;
    logic       pend;
  } exp_t;

  exp_t q[$];
  int   cyc = 0, epoch = 0, n_vec = 0, n_err = 0;
  logic [6:0] lut [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                           7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Hand-derived schedule: what the display register holds during state cycle s
  function automatic logic [15:0] disp_at(int ep, int s);
    if (ep != 0) return 16'h0000;
    if (s < 16) return 16'h0000;
    if (s < 32) return 16'h1234;
    if (s < 48) return 16'h0005;
    if (s < 64) return 16'h0000;
    if (s < 80) return 16'hABCD;
    return 16'h0070;
  endfunction

  function automatic logic pend_at(int ep, int c);
    if (ep != 0) return 1'b0;
    return (c >= 3 && c <= 15) || (c >= 21 && c <= 31) || (c >= 41 && c <= 47) ||
           (c >= 51 && c <= 63) || (c >= 67 && c <= 79) || (c >= 99);
  endfunction

  function automatic logic blank_at(int ep, int s);
    return ep == 0 && s >= 32;
  endfunction

  function automatic logic en_at(int ep, int s);
    return !(ep == 0 && s >= 80 && s < 96);
  endfunction

  function automatic logic [16:0] load_at(int ep, int c);
    if (ep != 0) return 17'h0;
    case (c)
      2:  return {1'b1, 16'h1234};
      20: return {1'b1, 16'h0005};
      40: return {1'b1, 16'h0000};
      50: return {1'b1, 16'h1111};
      63: return {1'b1, 16'hABCD};
      66: return {1'b1, 16'h0F00};
      68: return {1'b1, 16'h0070};
      98: return {1'b1, 16'h9999};
      default: return 17'h0;
    endcase
  endfunction

  task automatic push(int tag);
    exp_t        e;
    int          s, p, d;
    logic [15:0] dv, up;
    logic [3:0]  oh;
    s      = tag - 1;
    e.tag  = tag;
    e.pend = pend_at(epoch, tag);
    e.fd   = tag > 0 && tag % 16 == 0;
    e.seg  = 7'h7F;
    e.dig  = 4'hF;
    if (tag > 0) begin
      p  = s % 4;
      d  = (s / 4) % 4;
      dv = disp_at(epoch, s);
      up = dv >> (4 * d);
      oh = 4'b0001 << d;
      if (en_at(epoch, s) && p != 0) begin
        e.dig = ~oh;
        e.seg = (blank_at(epoch, s) && d > 0 && up == 16'h0) ? 7'h7F : ~lut[up[3:0]];
      end
    end
    q.push_back(e);
  endtask

  task automatic check(string name, int tag, logic [15:0] act, logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s epoch=%0d cycle=%0d: got %h expected %h", name, epoch, tag, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].tag < cyc) begin
        e = q.pop_front();
        check("missed", e.tag, 16'(cyc), 16'(e.tag));
      end
      if (q.size() > 0 && q[0].tag == cyc) begin
        e = q.pop_front();
        check("segments", e.tag, 16'(seg), 16'(e.seg));
        check("digit_en", e.tag, 16'(dig), 16'(e.dig));
        check("frame_done", e.tag, 16'(fd), 16'(e.fd));
        check("pending", e.tag, 16'(pend), 16'(e.pend));
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    epoch = 0;
    cyc   = 0;
    push(0);
    while (cyc < 102) begin
      {load, value} = load_at(epoch, cyc);
      blank = blank_at(epoch, cyc);
      en    = en_at(epoch, cyc);
      if (cyc < 101) push(cyc + 1);
      @(posedge clk);
      #1;
      cyc++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_seg", cyc, 16'(seg), 16'h7F);
    check("rst_async_dig", cyc, 16'(dig), 16'hF);
    check("rst_async_fd", cyc, 16'(fd), 16'h0);
    check("rst_async_pend", cyc, 16'(pend), 16'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_seg", cyc, 16'(seg), 16'h7F);
    check("rst_hold_dig", cyc, 16'(dig), 16'hF);
    check("rst_hold_pend", cyc, 16'(pend), 16'h0);
    #1;
    epoch = 1;
    cyc   = 0;
    rst_n = 1'b1;
    push(0);
    while (cyc < 35) begin
      {load, value} = load_at(epoch, cyc);
      blank = blank_at(epoch, cyc);
      en    = en_at(epoch, cyc);
      if (cyc < 34) push(cyc + 1);
      @(posedge clk);
      #1;
      cyc++;
    end
    @(negedge clk);
    #1;
    check("queue_drained", cyc, 16'(q.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
